unidade_controle_rodadas: RTL and testbench

Parametrised control unit for the werewolf game covering full rounds. It sequences game setup, a night phase visiting every living player in index order, and an optional day voting phase, looping until the datapath flags end of game. It owns the player counter and skips dead players using the datapath's alive mask. The datapath keeps the seed register, role table, alive mask and win detection.

---
 rtl/unidade_controle_rodadas.sv | 164 ++++++++++++++++
 tb/tb_unidade_controle_rodadas.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_rodadas.sv
// Round sequencer for the werewolf game: setup, night visits of living players, optional day vote (define VOTACAO_EN).
// Latency: one search cycle per visited player; outputs decode from the registered state only.
// Backpressure: holds in PREPARA_JOGO/DELAY_*/TURNO_* until passa; jogar is honoured only in INICIAL/FIM_JOGO.
module unidade_controle_rodadas #(
    parameter int N_JOGADORES = 8,
    parameter int W_JOG       = $clog2(N_JOGADORES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   jogar,
    input  logic                   passa,
    input  logic [N_JOGADORES-1:0] vivos,
    input  logic                   fim_jogo,
    output logic                   rst_global,
    output logic                   zera_CS,
    output logic                   inc_seed,
    output logic                   e_seed_reg,
    output logic                   mostra_classe,
    output logic                   habilita_voto,
    output logic                   fase_dia,
    output logic [W_JOG-1:0]       jogador_atual,
    output logic [7:0]             rodada,
    output logic [4:0]             db_estado
);

    localparam int WB = W_JOG + 1;

    typedef enum logic [4:0] {
        INICIAL       = 5'd0,
        RESETA_TUDO   = 5'd1,
        PREPARA_JOGO  = 5'd2,
        ARMAZENA_JOGO = 5'd3,
        PREPARA_NOITE = 5'd4,
        BUSCA_NOITE   = 5'd5,
        DELAY_NOITE   = 5'd6,
        TURNO_NOITE   = 5'd7,
        FIM_NOITE     = 5'd8,
        PREPARA_DIA   = 5'd9,
        BUSCA_DIA     = 5'd10,
        DELAY_DIA     = 5'd11,
        TURNO_DIA     = 5'd12,
        FIM_DIA       = 5'd13,
        FIM_JOGO      = 5'd14
    } estado_t;

    estado_t          estado;
    estado_t          prox_estado;
    logic [WB-1:0]    base;
    logic             achou;
    logic [W_JOG-1:0] prox;

    // Descending scan so the last hit is the lowest living index at or above base.
    always_comb begin
        achou = 1'b0;
        prox  = '0;
        for (int i = N_JOGADORES - 1; i >= 0; i--) begin
            if (vivos[i] && (WB'(i) >= base)) begin
                achou = 1'b1;
                prox  = W_JOG'(i);
            end
        end
    end

    always_comb begin
        prox_estado   = estado;
        db_estado     = estado;
        rst_global    = 1'b0;
        zera_CS       = 1'b0;
        inc_seed      = 1'b0;
        e_seed_reg    = 1'b0;
        mostra_classe = 1'b0;
        habilita_voto = 1'b0;
        fase_dia      = 1'b0;
        case (estado)
            INICIAL: begin
                rst_global = 1'b1;
                zera_CS    = 1'b1;
                if (jogar) prox_estado = RESETA_TUDO;
            end
            RESETA_TUDO: begin
                rst_global  = 1'b1;
                zera_CS     = 1'b1;
                prox_estado = PREPARA_JOGO;
            end
            PREPARA_JOGO: begin
                inc_seed = 1'b1;
                if (passa) prox_estado = ARMAZENA_JOGO;
            end
            ARMAZENA_JOGO: begin
                e_seed_reg  = 1'b1;
                prox_estado = PREPARA_NOITE;
            end
            PREPARA_NOITE: prox_estado = BUSCA_NOITE;
            BUSCA_NOITE:   prox_estado = achou ? DELAY_NOITE : FIM_NOITE;
            DELAY_NOITE:   if (passa) prox_estado = TURNO_NOITE;
            TURNO_NOITE: begin
                mostra_classe = 1'b1;
                if (passa) prox_estado = BUSCA_NOITE;
            end
`ifdef VOTACAO_EN
            FIM_NOITE:     prox_estado = fim_jogo ? FIM_JOGO : PREPARA_DIA;
            PREPARA_DIA: begin
                fase_dia    = 1'b1;
                prox_estado = BUSCA_DIA;
            end
            BUSCA_DIA: begin
                fase_dia    = 1'b1;
                prox_estado = achou ? DELAY_DIA : FIM_DIA;
            end
            DELAY_DIA: begin
                fase_dia = 1'b1;
                if (passa) prox_estado = TURNO_DIA;
            end
            TURNO_DIA: begin
                fase_dia      = 1'b1;
                habilita_voto = 1'b1;
                if (passa) prox_estado = BUSCA_DIA;
            end
            FIM_DIA: begin
                fase_dia    = 1'b1;
                prox_estado = fim_jogo ? FIM_JOGO : PREPARA_NOITE;
            end
`else
            FIM_NOITE:     prox_estado = fim_jogo ? FIM_JOGO : PREPARA_NOITE;
`endif
            FIM_JOGO:      if (jogar) prox_estado = RESETA_TUDO;
            default: begin
                db_estado   = 5'b11111;
                prox_estado = INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado        <= INICIAL;
            jogador_atual <= '0;
            base          <= '0;
            rodada        <= '0;
        end else begin
            estado <= prox_estado;
            case (estado)
                RESETA_TUDO: begin
                    jogador_atual <= '0;
                    base          <= '0;
                    rodada        <= '0;
                end
                PREPARA_NOITE: begin
                    base <= '0;
                    if (rodada != 8'hFF) rodada <= rodada + 8'd1;
                end
                BUSCA_NOITE: if (achou) jogador_atual <= prox;
                TURNO_NOITE: if (passa) base <= {1'b0, jogador_atual} + WB'(1);
`ifdef VOTACAO_EN
                PREPARA_DIA: base <= '0;
                BUSCA_DIA:   if (achou) jogador_atual <= prox;
                TURNO_DIA:   if (passa) base <= {1'b0, jogador_atual} + WB'(1);
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Plays randomized games against a visit-list model of the rounds; a monitor pops the expected
// visit/end-of-phase events as the design reaches them and checks output decode every cycle.
`timescale 1ns/1ps
module tb_unidade_controle_rodadas;

    localparam int N  = 8;
    localparam int WJ = $clog2(N);
`ifdef VOTACAO_EN
    localparam bit VOT = 1'b1;
`else
    localparam bit VOT = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          jogar = 1'b0;
    logic          passa = 1'b0;
    logic          fim_jogo = 1'b0;
    logic [N-1:0]  vivos = '0;
    logic          rst_global, zera_CS, inc_seed, e_seed_reg;
    logic          mostra_classe, habilita_voto, fase_dia;
    logic [WJ-1:0] jogador_atual;
    logic [7:0]    rodada;
    logic [4:0]    db_estado;

    always #5 clock = ~clock;

    unidade_controle_rodadas #(.N_JOGADORES(N), .W_JOG(WJ)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .passa(passa), .vivos(vivos),
        .fim_jogo(fim_jogo), .rst_global(rst_global), .zera_CS(zera_CS),
        .inc_seed(inc_seed), .e_seed_reg(e_seed_reg), .mostra_classe(mostra_classe),
        .habilita_voto(habilita_voto), .fase_dia(fase_dia),
        .jogador_atual(jogador_atual), .rodada(rodada), .db_estado(db_estado)
    );

    typedef struct {
        int st;
        int jog;
        int rod;
    } ev_t;

    ev_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  m_jog = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string nome, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nome, got, exp);
        end
    endtask

    function automatic int alto(input logic [N-1:0] m);
        int h = -1;
        for (int i = 0; i < N; i++) if (m[i]) h = i;
        return h;
    endfunction

    function automatic logic [N-1:0] mascara(input int modo, input int r);
        int s;
        if (modo == 1) return (r % 32 == 0) ? N'($urandom) : '0;
        if (r == 1) return 8'hFF;
        if (r == 2) return 8'b1010_0100;
        if (r == 3) return '0;
        if (r == 4) return 8'h03;
        s = $urandom_range(7);
        if (s == 0) return '0;
        if (s == 1) return 8'hFF;
        return N'($urandom);
    endfunction

    // Pushes one phase worth of visits: each living player in index order, then the phase end marker.
    task automatic empurra_fase(input int st_visita, input int st_fim, input int r, input bit fim);
        int rm;
        int h;
        rm = (r > 255) ? 255 : r;
        h  = alto(vivos);
        for (int i = 0; i < N; i++)
            if (vivos[i]) sb.push_back('{st_visita, i, rm});
        if (h >= 0) m_jog = h;
        sb.push_back('{st_fim, m_jog, rm});
        if (fim) sb.push_back('{14, m_jog, rm});
    endtask

    initial begin : monitor
        int prev;
        int cur;
        ev_t e;
        logic [6:0] ex;
        logic [6:0] ac;
        prev = -1;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                cur = int'(db_estado);
                chk("estado_valido", int'(cur <= 14 && (VOT || cur < 9 || cur > 13)), 1);
                ex = {cur <= 1, cur <= 1, cur == 2, cur == 3, cur == 7,
                      VOT && cur == 12, VOT && cur >= 9 && cur <= 13};
                ac = {rst_global, zera_CS, inc_seed, e_seed_reg, mostra_classe, habilita_voto, fase_dia};
                chk("saidas_moore", int'(ac), int'(ex));
                if (prev == 5)  chk("busca_noite_1ciclo", int'(cur == 6 || cur == 8), 1);
                if (prev == 10) chk("busca_dia_1ciclo", int'(cur == 11 || cur == 13), 1);
                if (cur != prev && (cur == 6 || cur == 8 || cur == 11 || cur == 13 || cur == 14)) begin
                    if (sb.size() == 0) begin
                        chk("evento_inesperado", cur, -1);
                    end else begin
                        e = sb.pop_front();
                        tests++;
                        if (e.st != cur || e.jog != int'(jogador_atual) || e.rod != int'(rodada)) begin
                            fails++;
                            $display("FAIL evento: got st=%0d jog=%0d rod=%0d expected st=%0d jog=%0d rod=%0d",
                                     cur, jogador_atual, rodada, e.st, e.jog, e.rod);
                        end
                    end
                end
                prev = cur;
            end else begin
                prev = -1;
            end
        end
    end

    task automatic wait_state(input int code, input int budget);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (int'(db_estado) != code && n < budget);
        if (int'(db_estado) != code) chk("timeout_espera", int'(db_estado), code);
    endtask

    task automatic do_reset();
        reset = 1'b0; jogar = 1'b0; passa = 1'b0; fim_jogo = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_estado", int'(db_estado), 0);
        chk("reset_strobes", int'({rst_global, zera_CS, inc_seed, e_seed_reg,
                                   mostra_classe, habilita_voto, fase_dia}), 7'b1100000);
        chk("reset_jogador", int'(jogador_atual), 0);
        chk("reset_rodada", int'(rodada), 0);
        mon_en = 1'b1;
        reset  = 1'b1;
    endtask

    task automatic start_game();
        jogar = 1'b1;
        @(negedge clock); chk("inicio_estado1", int'(db_estado), 1);
        @(negedge clock); chk("inicio_estado2", int'(db_estado), 2);
        chk("inicio_rodada0", int'(rodada), 0);
        chk("inicio_jogador0", int'(jogador_atual), 0);
        jogar = 1'b0;
        passa = 1'b1;
        @(negedge clock); chk("inicio_estado3", int'(db_estado), 3);
        passa = 1'b0;
        m_jog = 0;
    endtask

    task automatic run_game(input int nr, input int modo, input int budget);
        int r = 0;
        int cyc = 0;
        int st;
        int q;
        int h;
        bit plan = 1'b0;
        bit fim_n;
        bit fim_d = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (cyc > budget) begin
                chk("timeout_jogo", cyc, budget);
                break;
            end
            st = int'(db_estado);
            if (st == 14) break;
            if (st == 4) begin
                r++;
                vivos = mascara(modo, r);
                fim_n = 1'b0;
                fim_d = 1'b0;
                if (r == nr) begin
                    if (VOT && $urandom_range(1) == 1) fim_d = 1'b1;
                    else fim_n = 1'b1;
                end
                plan = fim_n;
                empurra_fase(6, 8, r, fim_n);
            end
            if (st == 9) begin
                plan = fim_d;
                empurra_fase(11, 13, r, fim_d);
            end
            // A death mid-turn removes that player's pending visit; the highest living player is spared.
            if (st == 7 && $urandom_range(3) == 0) begin
                q = $urandom_range(N - 1);
                h = alto(vivos);
                if (vivos[q] && q != h) begin
                    vivos[q] = 1'b0;
                    for (int k = sb.size() - 1; k >= 0; k--)
                        if (sb[k].st == 6 && sb[k].jog == q) sb.delete(k);
                end
            end
            passa    = 1'($urandom_range(1));
            jogar    = 1'($urandom_range(1));
            fim_jogo = (st == 5 || st == 8 || st == 10 || st == 13) ? plan : 1'($urandom_range(1));
        end
        passa = 1'b0; jogar = 1'b0; fim_jogo = 1'b0;
        @(negedge clock);
        chk("fila_vazia_fim", sb.size(), 0);
        chk("fim_jogo_estado14", int'(db_estado), 14);
    endtask

    initial begin
        do_reset();
        start_game(); run_game(6, 0, 6000);
        start_game(); run_game(5, 0, 6000);
        start_game(); run_game(260, 1, 30000);

        // Reset in the middle of player 5's night turn.
        start_game();
        wait_state(4, 20);
        vivos = 8'h20;
        fim_jogo = 1'b0;
        sb.push_back('{6, 5, 1});
        wait_state(6, 20);
        passa = 1'b1;
        @(negedge clock);
        chk("turno_estado7", int'(db_estado), 7);
        chk("turno_jogador5", int'(jogador_atual), 5);
        passa = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("reset_meio_estado", int'(db_estado), 0);
        chk("reset_meio_jogador", int'(jogador_atual), 0);
        chk("reset_meio_rodada", int'(rodada), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("fila_vazia_final", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
